// File: rtl/lock_code_sender_if.sv
// ----------------------------------------------------------------------------
// lock_code_sender_if
//   Digit/req/ack link between the clocked code sender and the async lock.
//
//   digit_out    digit presented to the lock (sender -> lock)
//   req_out      4-phase request              (sender -> lock)
//   ack_in       4-phase acknowledge, async   (lock -> sender)
//   unlocked_in  lock status, async           (lock -> sender)
//
//   master : the code sender
//   slave  : the lock (or a model of it)
// ----------------------------------------------------------------------------
interface lock_code_sender_if #(
    parameter int DIGIT_W = 4
);
    logic [DIGIT_W-1:0] digit_out;
    logic               req_out;
    logic               ack_in;
    logic               unlocked_in;

    modport master (
        output digit_out,
        output req_out,
        input  ack_in,
        input  unlocked_in
    );

    modport slave (
        input  digit_out,
        input  req_out,
        output ack_in,
        output unlocked_in
    );
endinterface

// File: rtl/lock_code_sender.sv
// ----------------------------------------------------------------------------
// lock_code_sender
//   Serialises a stored DIGITS-digit code (MS digit first) onto the async
//   lock's digit/req/ack link with a 4-phase handshake, then watches the
//   lock's unlocked line for RESULT_WAIT cycles and reports the outcome.
//
//   Ports
//     clk, rst_n   clock, synchronous active-low reset
//     ena          freezes FSM, counters and outputs while low
//     start        one-cycle request, accepted only in IDLE
//     code_in      code, MS digit first, captured on accepted start
//     lk           master side of lock_code_sender_if (digit/req/ack/unlocked)
//     busy         high from the cycle after start through the done cycle
//     done         one-cycle completion pulse
//     pass         sticky: unlocked seen during the last sequence
//     err          sticky: handshake watchdog abort
//
//   Build option
//     HS_TIMEOUT_EN  adds a watchdog on REQ_HI/REQ_LO that aborts after
//                    TIMEOUT cycles in one state. Without it the handshake
//                    waits forever and err is tied low.
// ----------------------------------------------------------------------------
module lock_code_sender #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int RESULT_WAIT = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      start,
    input  logic [DIGITS*DIGIT_W-1:0] code_in,
    lock_code_sender_if.master        lk,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      err
);
    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W  = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, REQ_HI, REQ_LO, NEXT, CHECK, FIN
    } state_t;

    state_t state, state_nxt;

    logic              ack_meta, ack_s, unl_meta, unl_s;
    logic [CODE_W-1:0] code_sr, code_sr_nxt;
    logic [DIGIT_W-1:0] digit_q, digit_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              req_q, req_nxt;
    logic              busy_nxt, done_nxt, pass_nxt;

    assign lk.digit_out = digit_q;
    assign lk.req_out   = req_q;

    // Two-flop synchronisers; kept running regardless of ena so the
    // synchronised view is current when the FSM resumes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
            unl_meta <= 1'b0;
            unl_s    <= 1'b0;
        end else begin
            ack_meta <= lk.ack_in;
            ack_s    <= ack_meta;
            unl_meta <= lk.unlocked_in;
            unl_s    <= unl_meta;
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_clr, wd_fire;
    logic            err_q, err_nxt;

    // Fires on the cycle whose edge would bring the count to TIMEOUT, so the
    // abort lands exactly TIMEOUT cycles after entering the handshake state.
    assign wd_fire = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (ena) begin
            wd_cnt <= wd_clr ? '0 : wd_cnt + 1'b1;
            err_q  <= err_nxt;
        end
    end
`else
    assign err = 1'b0;

    // TIMEOUT only matters with the watchdog built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_nxt   = state;
        code_sr_nxt = code_sr;
        digit_nxt   = digit_q;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        req_nxt     = req_q;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        pass_nxt    = pass;
`ifdef HS_TIMEOUT_EN
        err_nxt     = err_q;
        wd_clr      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    code_sr_nxt = code_in;
                    digit_nxt   = code_in[CODE_W-1 -: DIGIT_W];
                    idx_nxt     = '0;
                    pass_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
`ifdef HS_TIMEOUT_EN
                    err_nxt     = 1'b0;
`endif
                    state_nxt   = SETUP;
                end
            end
            // digit_out was loaded on the way in; this cycle is settle time.
            SETUP: begin
                req_nxt   = 1'b1;
                state_nxt = REQ_HI;
`ifdef HS_TIMEOUT_EN
                wd_clr    = 1'b1;
`endif
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = REQ_LO;
`ifdef HS_TIMEOUT_EN
                    wd_clr    = 1'b1;
`endif
                end
`ifdef HS_TIMEOUT_EN
                else if (wd_fire) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end
`endif
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_nxt = NEXT;
                end
`ifdef HS_TIMEOUT_EN
                else if (wd_fire) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end
`endif
            end
            // The only place digit_out changes mid-sequence: req and ack_s
            // are both low here.
            NEXT: begin
                if (idx == IDX_W'(DIGITS - 1)) begin
                    cnt_nxt   = CNT_W'(RESULT_WAIT - 1);
                    state_nxt = CHECK;
                end else begin
                    idx_nxt     = idx + 1'b1;
                    code_sr_nxt = code_sr << DIGIT_W;
                    digit_nxt   = code_sr_nxt[CODE_W-1 -: DIGIT_W];
                    state_nxt   = SETUP;
                end
            end
            CHECK: begin
                if (unl_s) begin
                    pass_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end else if (cnt == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            FIN: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            code_sr <= '0;
            digit_q <= '0;
            idx     <= '0;
            cnt     <= '0;
            req_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else if (ena) begin
            state   <= state_nxt;
            code_sr <= code_sr_nxt;
            digit_q <= digit_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            req_q   <= req_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            pass    <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_lock_code_sender.sv
// ----------------------------------------------------------------------------
// tb_lock_code_sender
//   Stimulus issues code sequences and pushes the expected outcome (digit
//   list, pass, err) into a scoreboard queue. A lock model answers the
//   handshake with a configurable ack delay and raises unlocked two cycles
//   after the last ack falls if the received digits match its secret. A
//   monitor pops and compares on every done pulse.
// ----------------------------------------------------------------------------
module tb_lock_code_sender;
    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;
    localparam int RESULT_WAIT = 16;
    localparam int TIMEOUT     = 20;
    localparam int CODE_W      = DIGITS * DIGIT_W;

    typedef struct {
        logic [CODE_W-1:0] code;
        int                n_dig;
        logic              pass;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic              start = 1'b0;
    logic [CODE_W-1:0] code_in = '0;
    logic              busy, done, pass, err;

    lock_code_sender_if #(.DIGIT_W(DIGIT_W)) lk ();

    lock_code_sender #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W),
        .RESULT_WAIT(RESULT_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .code_in(code_in), .lk(lk),
        .busy(busy), .done(done), .pass(pass), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- lock model ----------------
    logic [7:0]         hist = '0;
    int                 ack_dly = 3;
    logic               ack_stuck = 1'b0;
    logic [CODE_W-1:0]  secret = '0;
    logic [DIGIT_W-1:0] rx_q[$];
    logic [DIGIT_W-1:0] held = '0;
    logic               req_prev = 1'b0;
    logic               nack;
    logic [CODE_W-1:0]  got;
    int                 falls = 0;
    int                 unl_wait = -1;
    int                 last_fall_cyc = 0;

    initial begin
        lk.ack_in      = 1'b0;
        lk.unlocked_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            hist = {hist[6:0], lk.req_out};
            nack = ack_stuck ? 1'b0 : hist[ack_dly];
            if (!rst_n || (start && ena && !busy)) begin
                rx_q.delete();
                falls          = 0;
                unl_wait       = -1;
                lk.unlocked_in = 1'b0;
            end else begin
                if (lk.req_out && !req_prev) begin
                    rx_q.push_back(lk.digit_out);
                    held = lk.digit_out;
                end else if (lk.req_out) begin
                    check("digit_stable", lk.digit_out, held);
                end
                if (unl_wait > 0) unl_wait--;
                if (unl_wait == 0) begin
                    got = '0;
                    foreach (rx_q[i]) got = (got << DIGIT_W) | CODE_W'(rx_q[i]);
                    lk.unlocked_in = (rx_q.size() == DIGITS) && (got == secret);
                    unl_wait = -1;
                end
                if (lk.ack_in && !nack) begin
                    falls++;
                    if (falls == DIGITS) begin
                        last_fall_cyc = cyc;
                        unl_wait      = 2;
                    end
                end
            end
            req_prev  = lk.req_out;
            lk.ack_in = nack;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t              cur;
    logic [CODE_W-1:0] sh;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: done=1 with no sequence outstanding (cycle %0d)", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    check("pass", pass, cur.pass);
                    check("err", err, cur.err);
                    check("req_pulses", rx_q.size(), cur.n_dig);
                    for (int i = 0; i < cur.n_dig && i < rx_q.size(); i++) begin
                        sh = cur.code >> (DIGIT_W * (DIGITS - 1 - i));
                        check("digit_order", rx_q[i], sh[DIGIT_W-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at 1ns after the edge that accepted start.
    task automatic launch(input logic [CODE_W-1:0] c, input logic [CODE_W-1:0] sec,
                          input int ndig, input logic werr);
        exp_t e;
        secret  = sec;
        e.code  = c;
        e.n_dig = ndig;
        e.err   = werr;
        e.pass  = !werr && (c == sec);
        exp_q.push_back(e);
        code_in = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Optional random ena freezes, only while req is high.
    task automatic wait_done(input int limit, output int dc, input bit frz);
        int n;
        for (int k = 0; k < limit && !done; k++) begin
            if (frz && lk.req_out && $urandom_range(0, 5) == 0) begin
                ena = 1'b0;
                n   = $urandom_range(1, 3);
                repeat (n) begin
                    tick();
                    check("ena_hold_req", lk.req_out, 1);
                end
                ena = 1'b1;
            end
            tick();
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", limit);
        end
        dc = cyc;
    endtask

    initial begin
        int                dc, r, lowcnt;
        logic [CODE_W-1:0] c, sec;

        // Reset with start held high.
        rst_n   = 1'b0;
        start   = 1'b1;
        code_in = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {busy, done, pass, err, lk.req_out, lk.digit_out}, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick(2);
        check("idle_after_reset", {busy, lk.req_out}, 0);

        // Nominal: ack = req delayed 3 cycles, lock opens.
        ack_dly = 3;
        launch(16'h3A7C, 16'h3A7C, DIGITS, 1'b0);
        check("busy_t1", busy, 1);
        check("digit_t1", lk.digit_out, 4'h3);
        check("req_t1", lk.req_out, 0);
        tick();
        check("req_t2", lk.req_out, 1);
        wait_done(600, dc, 1'b0);
        tick();
        check("done_one_cycle", done, 0);
        check("pass_sticky", pass, 1);

        // Start in the cycle after done is accepted and clears pass; a start
        // during digit 2 is ignored.
        launch(16'h3A7C, 16'h3A7C, DIGITS, 1'b0);
        check("restart_clears_pass", pass, 0);
        check("restart_busy", busy, 1);
        for (int k = 0; k < 200 && rx_q.size() < 2; k++) tick();
        check("reached_digit2", rx_q.size(), 2);
        code_in = 16'hFFFF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done(600, dc, 1'b0);
        tick();

        // Wrong code: CHECK is entered 4 edges after the last ack falls
        // (2 sync flops, REQ_LO->NEXT, NEXT->CHECK), then RESULT_WAIT more.
        launch(16'h3A7C, 16'h3A7D, DIGITS, 1'b0);
        wait_done(600, dc, 1'b0);
        check("check_window", dc - last_fall_cyc, RESULT_WAIT + 4);
        tick(3);
        check("fail_pass_sticky", pass, 0);

        // Reset mid-handshake, then a clean resend from digit 0.
        launch(16'h5E19, 16'h5E19, DIGITS, 1'b0);
        for (int k = 0; k < 200 && !(rx_q.size() == 2 && lk.req_out); k++) tick();
        check("mid_req_high", lk.req_out, 1);
        rst_n = 1'b0;
        tick();
        check("rst_req_drop", lk.req_out, 0);
        check("rst_busy_drop", busy, 0);
        exp_q.delete();
        rst_n = 1'b1;
        tick(10);
        launch(16'h5E19, 16'h5E19, DIGITS, 1'b0);
        wait_done(600, dc, 1'b0);
        tick();

        // Randomised sequences with random ack delay and ena freezes.
        for (int n = 0; n < 24; n++) begin
            c       = CODE_W'($urandom);
            sec     = ($urandom_range(0, 1) == 1) ? c
                    : c ^ (CODE_W'(1) << $urandom_range(0, CODE_W - 1));
            ack_dly = $urandom_range(1, 4);
            launch(c, sec, DIGITS, 1'b0);
            wait_done(800, dc, 1'b1);
            tick();
        end

        // Lock never acknowledges.
        ack_dly   = 1;
        ack_stuck = 1'b1;
`ifdef HS_TIMEOUT_EN
        launch(16'hBEEF, 16'hBEEF, 1, 1'b1);
        tick();
        check("wd_req_rise", lk.req_out, 1);
        r = cyc;
        wait_done(200, dc, 1'b0);
        check("wd_latency", dc - r, TIMEOUT);
        check("wd_req_low", lk.req_out, 0);
        ack_stuck = 1'b0;
        tick(3);
        check("wd_err_sticky", err, 1);
`else
        launch(16'hBEEF, 16'hBEEF, DIGITS, 1'b0);
        lowcnt = 0;
        repeat (1000) begin
            tick();
            if (!busy) lowcnt++;
        end
        check("stuck_busy_held", lowcnt, 0);
        check("stuck_req_held", lk.req_out, 1);
        check("err_tied_low", err, 0);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        rst_n     = 1'b1;
        ack_stuck = 1'b0;
        tick(10);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
